regfiletmp_commit: RTL
======================

Name: regfiletmp_commit

Overview:
In-order allocate/retire controller for the speculative temp register file (73-bit entries: rd_reg[72:68], PC[67:36], Inst_type[35:34], spec_data[33:2], spec_valid[1], valid[0]).
- Allocates entry tags to dispatched instructions in program order.
- Owns the temp file's single write port, merging dispatch New_entry writes with CDB Update_entry writes.
- Reads the head entry and retires completed results in order into the architectural register file.

Parameters:
- DEPTH, 32, number of temp-file entries; power of two.
- AW, 5, tag/address width; log2(DEPTH).
- DW, 32, data width of spec_data.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; discards all in-flight entries
- alloc_req  in  1  dispatch requests a tag
- alloc_rd  in  5  destination register of dispatched instruction
- alloc_pc  in  32  PC of dispatched instruction
- alloc_type  in  2  Inst_type: 00 ALU-write, 01 store, 10 branch, 11 other
- alloc_ack  out  1  tag granted this cycle
- alloc_tag  out  AW  granted tag (equals tail)
- cdb_valid  in  1  execution result available
- cdb_tag  in  AW  tag of result
- cdb_data  in  DW  result value
- cdb_ready  out  1  CDB result accepted this cycle
- tmp_new_entry  out  1  to temp file New_entry
- tmp_update_entry  out  1  to temp file Update_entry
- tmp_waddr  out  AW  to temp file Waddr
- tmp_data_in  out  73  to temp file Data_In
- tmp_rd_addr  out  AW  to temp file Rd_Addr1 (equals head)
- tmp_rd_data  in  73  from temp file Data_out1
- arf_we  out  1  architectural write enable, registered
- arf_waddr  out  5  architectural write address, registered
- arf_wdata  out  DW  architectural write data, registered
- commit_valid  out  1  one instruction retired, registered
- commit_pc  out  32  PC of retired instruction, registered

Behaviour:
- State: head, tail (AW bits, wrap modulo DEPTH), count (AW+1 bits).
- Reset (synchronous): head=tail=count=0; arf_we=0, arf_waddr=0, arf_wdata=0, commit_valid=0, commit_pc=0.
- Allocation:
  - alloc_ack = alloc_req && count!=DEPTH (combinational from registered count); alloc_tag = tail.
  - On ack: tmp_new_entry=1, tmp_waddr=tail, tmp_data_in={alloc_rd, alloc_pc, alloc_type, 32'b0, 1'b0, 1'b1}; tail increments at the clock edge.
- CDB update:
  - cdb_ready = !alloc_ack. Dispatch has priority, matching the temp file's New_entry-over-Update_entry priority.
  - On cdb_valid && cdb_ready: tmp_update_entry=1, tmp_waddr=cdb_tag, tmp_data_in[33:2]=cdb_data, tmp_data_in[1]=1; all other bits 0.
  - A rejected CDB result is held by the producer.
- Retire:
  - commit_fire = count!=0 && tmp_rd_data[0] && tmp_rd_data[1] && !flush.
  - On fire: head++, and next cycle commit_valid=1, commit_pc=tmp_rd_data[67:36].
  - arf_we=1 only when Inst_type==00 and rd_reg!=0; arf_waddr=rd_reg, arf_wdata=spec_data.
  - Otherwise the registered outputs drop to 0 (commit_valid, arf_we) the next cycle.
  - At most one retire per cycle. Latency from CDB acceptance of the head tag to arf_we is 2 cycles.
- count next = count + alloc_ack − commit_fire. Simultaneous alloc and retire keeps count unchanged.
- Full: alloc is refused even if a retire happens the same cycle.
- Empty: no retire; a stale valid head entry is ignored.
- flush: at the edge, head=tail=count=0; arf_we and commit_valid are 0 next cycle. An alloc_ack in the flush cycle is discarded.
- tmp_new_entry and tmp_update_entry are never both 1.

Optional Feature:
RETIRE_CNT_EN:
- Defined: adds output retire_count (32 bits), reset to 0, incremented on every commit_fire, not cleared by flush, wraps at 2^32.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package regfiletmp_pkg holds:
  - field bit-position constants (RD_HI=72, RD_LO=68, PC_HI=67, PC_LO=36, TYPE_HI=35, TYPE_LO=34, SD_HI=33, SD_LO=2, SV_BIT=1, V_BIT=0);
  - Inst_type encodings (ITYPE_ALU=2'b00, ITYPE_STORE=2'b01, ITYPE_BRANCH=2'b10, ITYPE_OTHER=2'b11);
  - the entry width 73.
- One sub-module, regfiletmp_wrport_mux: combinational alloc/CDB arbitration and tmp_data_in packing.

Test Plan:
1. Reset, then alloc rd=5,6,7 on consecutive cycles -> alloc_tag 0,1,2; tmp_new_entry=1 each cycle, tmp_data_in[0]=1, [1]=0; count=3.
2. CDB tag1=0xAA, then tag0=0x55 -> no arf_we after tag1. Two cycles after tag0: arf_we=1, waddr=5, wdata=0x55; next cycle waddr=6, wdata=0xAA.
3. 32 allocs without retire -> 33rd alloc_ack=0. Complete and retire tag0 -> next alloc_ack=1 with alloc_tag=0 (wrap).
4. alloc_req and cdb_valid in the same cycle -> cdb_ready=0, tmp_update_entry=0, tmp_new_entry=1. Next cycle (no alloc) cdb_ready=1 and the update is written.
5. Retire entry with alloc_type=01 or rd=0, data 0x1234 -> commit_valid=1, arf_we=0, count decrements.
6. 4 entries pending, 2 completed, assert flush -> next cycle count=0, arf_we=0. Next alloc gets tag 0.

Source files
------------

// File: rtl/regfiletmp_pkg.sv
// regfiletmp_pkg
// Shared definitions for the speculative temp register file controller:
// 73-bit entry layout (bit positions of each field), Inst_type encodings
// and the entry width.
package regfiletmp_pkg;

  localparam int ENTRY_W = 73;

  // Entry layout: {rd_reg, PC, Inst_type, spec_data, spec_valid, valid}
  localparam int RD_HI   = 72;
  localparam int RD_LO   = 68;
  localparam int PC_HI   = 67;
  localparam int PC_LO   = 36;
  localparam int TYPE_HI = 35;
  localparam int TYPE_LO = 34;
  localparam int SD_HI   = 33;
  localparam int SD_LO   = 2;
  localparam int SV_BIT  = 1;
  localparam int V_BIT   = 0;

  typedef enum logic [1:0] {
    ITYPE_ALU    = 2'b00,
    ITYPE_STORE  = 2'b01,
    ITYPE_BRANCH = 2'b10,
    ITYPE_OTHER  = 2'b11
  } itype_e;

endpackage

// File: rtl/regfiletmp_wrport_mux.sv
// regfiletmp_wrport_mux
// Combinational arbitration of the temp file's single write port between
// dispatch allocation (New_entry) and CDB results (Update_entry), plus
// packing of the 73-bit Data_In word.
// Ports:
//   i_alloc_req   dispatch requests a tag
//   i_alloc_ok    the file has a free entry (count != DEPTH)
//   i_tail        tag to grant
//   i_alloc_rd/pc/type  fields of the dispatched instruction
//   i_cdb_valid/tag/data  execution result
//   o_alloc_ack   tag granted
//   o_cdb_ready   CDB result accepted (only when no allocation)
//   o_new_entry / o_update_entry / o_waddr / o_data_in  temp file write port
module regfiletmp_wrport_mux
  import regfiletmp_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic               i_alloc_req,
  input  logic               i_alloc_ok,
  input  logic [AW-1:0]      i_tail,
  input  logic [4:0]         i_alloc_rd,
  input  logic [31:0]        i_alloc_pc,
  input  logic [1:0]         i_alloc_type,
  input  logic               i_cdb_valid,
  input  logic [AW-1:0]      i_cdb_tag,
  input  logic [DW-1:0]      i_cdb_data,
  output logic               o_alloc_ack,
  output logic               o_cdb_ready,
  output logic               o_new_entry,
  output logic               o_update_entry,
  output logic [AW-1:0]      o_waddr,
  output logic [ENTRY_W-1:0] o_data_in
);

  logic w_ack;

  assign w_ack       = i_alloc_req && i_alloc_ok;
  assign o_alloc_ack = w_ack;
  // Dispatch owns the port whenever it is granted, mirroring the temp
  // file's own New_entry-over-Update_entry priority.
  assign o_cdb_ready = !w_ack;

  always_comb begin
    o_new_entry    = 1'b0;
    o_update_entry = 1'b0;
    o_waddr        = '0;
    o_data_in      = '0;
    if (w_ack) begin
      o_new_entry                  = 1'b1;
      o_waddr                      = i_tail;
      o_data_in[RD_HI:RD_LO]       = i_alloc_rd;
      o_data_in[PC_HI:PC_LO]       = i_alloc_pc;
      o_data_in[TYPE_HI:TYPE_LO]   = i_alloc_type;
      o_data_in[V_BIT]             = 1'b1;
    end else if (i_cdb_valid) begin
      o_update_entry               = 1'b1;
      o_waddr                      = i_cdb_tag;
      o_data_in[SD_HI:SD_LO]       = i_cdb_data;
      o_data_in[SV_BIT]            = 1'b1;
    end
  end

endmodule

// File: rtl/regfiletmp_commit.sv
// regfiletmp_commit
// In-order allocate/retire controller for the speculative temp register
// file. Hands out tags in program order, drives the temp file's write port
// (dispatch or CDB), reads the head entry and retires completed results
// into the architectural register file, one per cycle.
// Ports:
//   clock, reset (sync, active-high), flush (discard all in-flight entries)
//   alloc_*   dispatch request / grant (alloc_tag = tail)
//   cdb_*     execution result input, cdb_ready = accepted
//   tmp_*     temp file write port and head read port
//   arf_*     registered architectural register file write
//   commit_*  registered retire indication and PC
// Optional: define RETIRE_CNT_EN to add the 32-bit retire_count output
// (counts every retire, survives flush, wraps).
module regfiletmp_commit
  import regfiletmp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               alloc_req,
  input  logic [4:0]         alloc_rd,
  input  logic [31:0]        alloc_pc,
  input  logic [1:0]         alloc_type,
  output logic               alloc_ack,
  output logic [AW-1:0]      alloc_tag,
  input  logic               cdb_valid,
  input  logic [AW-1:0]      cdb_tag,
  input  logic [DW-1:0]      cdb_data,
  output logic               cdb_ready,
  output logic               tmp_new_entry,
  output logic               tmp_update_entry,
  output logic [AW-1:0]      tmp_waddr,
  output logic [ENTRY_W-1:0] tmp_data_in,
  output logic [AW-1:0]      tmp_rd_addr,
  input  logic [ENTRY_W-1:0] tmp_rd_data,
`ifdef RETIRE_CNT_EN
  output logic [31:0]        retire_count,
`endif
  output logic               arf_we,
  output logic [4:0]         arf_waddr,
  output logic [DW-1:0]      arf_wdata,
  output logic               commit_valid,
  output logic [31:0]        commit_pc
);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic w_alloc_ok;
  logic w_alloc_ack;
  logic w_commit_fire;
  logic w_arf_write;

  // Full check uses only the registered count, so a retire in the same
  // cycle never frees a slot for this cycle's allocation.
  assign w_alloc_ok = (r_count != (AW+1)'(DEPTH));

  regfiletmp_wrport_mux #(.AW(AW), .DW(DW)) u_wrport_mux (
    .i_alloc_req    (alloc_req),
    .i_alloc_ok     (w_alloc_ok),
    .i_tail         (r_tail),
    .i_alloc_rd     (alloc_rd),
    .i_alloc_pc     (alloc_pc),
    .i_alloc_type   (alloc_type),
    .i_cdb_valid    (cdb_valid),
    .i_cdb_tag      (cdb_tag),
    .i_cdb_data     (cdb_data),
    .o_alloc_ack    (w_alloc_ack),
    .o_cdb_ready    (cdb_ready),
    .o_new_entry    (tmp_new_entry),
    .o_update_entry (tmp_update_entry),
    .o_waddr        (tmp_waddr),
    .o_data_in      (tmp_data_in)
  );

  assign alloc_ack   = w_alloc_ack;
  assign alloc_tag   = r_tail;
  assign tmp_rd_addr = r_head;

  // Count gating keeps a stale completed entry at the head of an empty
  // file from retiring.
  assign w_commit_fire = (r_count != '0) && tmp_rd_data[V_BIT] &&
                         tmp_rd_data[SV_BIT] && !flush;

  // Only ALU results with a nonzero destination update architectural state.
  assign w_arf_write = (tmp_rd_data[TYPE_HI:TYPE_LO] == ITYPE_ALU) &&
                       (tmp_rd_data[RD_HI:RD_LO] != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      arf_we       <= 1'b0;
      arf_waddr    <= '0;
      arf_wdata    <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else if (flush) begin
      // Any grant made in this cycle is dropped along with the rest.
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      arf_we       <= 1'b0;
      commit_valid <= 1'b0;
    end else begin
      r_head       <= r_head + AW'(w_commit_fire);
      r_tail       <= r_tail + AW'(w_alloc_ack);
      r_count      <= r_count + (AW+1)'(w_alloc_ack) - (AW+1)'(w_commit_fire);
      commit_valid <= w_commit_fire;
      arf_we       <= w_commit_fire && w_arf_write;
      if (w_commit_fire) begin
        commit_pc <= tmp_rd_data[PC_HI:PC_LO];
        arf_waddr <= tmp_rd_data[RD_HI:RD_LO];
        arf_wdata <= DW'(tmp_rd_data[SD_HI:SD_LO]);
      end
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retire_count;

  // Lifetime retire counter: flush does not clear it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retire_count <= '0;
    end else if (w_commit_fire) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`endif

endmodule
